mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous program memory between two requesters: the programmer
//  (UART loader and debug path) and the CPU core (instruction/operand fetch and store).
//  In program mode the programmer owns the port exclusively. Otherwise requests are served
//  round-robin. Sits between cpu/programmer and the memory array, one access per 2 clocks.
// PARAMETERS
//  MEMORY_ADDRESS_WIDTH  4  address width; memory depth is 2**MEMORY_ADDRESS_WIDTH
//  DATA_WIDTH            8  memory word width
//  WP_LIMIT              8  CPU writes to addr < WP_LIMIT are blocked (only with macro)
// PORTS
//  clk_i           in   1    clock
//  reset_ni        in   1    asynchronous active-low reset
//  program_mode_i  in   1    1 = programmer has exclusive access
//  p_req_i         in   1    programmer request, held until p_gnt_o
//  p_we_i          in   1    programmer write(1)/read(0)
//  p_addr_i        in   AW   programmer address
//  p_wdata_i       in   DW   programmer write data
//  p_gnt_o         out  1    1-cycle pulse: programmer access issued this cycle
//  p_rvalid_o      out  1    1-cycle pulse: p_rdata_o valid
//  p_rdata_o       out  DW   programmer read data
//  c_req_i/c_we_i/c_addr_i/c_wdata_i  in   1/1/AW/DW  CPU request, same rules as programmer
//  c_gnt_o/c_rvalid_o/c_rdata_o       out  1/1/DW     CPU grant, read-valid and read data
//  mem_en_o        out  1    memory enable
//  mem_we_o        out  1    memory write enable
//  mem_addr_o      out  AW   memory address
//  mem_wdata_o     out  DW   memory write data
//  mem_rdata_i     in   DW   memory read data, valid 1 clk after mem_en_o
//  busy_o          out  1    1 while in state ACCESS
//  wp_err_o        out  1    1-cycle pulse: CPU write blocked
// BEHAVIOUR
//  - All outputs registered. Reset value of every output is 0. last_owner resets to CPU.
//  - FSM states: IDLE, ACCESS.
//    - IDLE: sample the requests and pick an owner.
//    - Captured addr/we/wdata are held in registers.
//    - If any eligible request exists, go to ACCESS. Otherwise stay in IDLE.
//  - Eligibility:
//    - program_mode_i=1: only p_req_i is eligible. c_req_i stays pending and is never dropped by the arbiter.
//    - program_mode_i=0: both are eligible. If both request, grant the one that is not last_owner.
//  - ACCESS (exactly 1 cycle):
//    - Drive mem_en_o=1, mem_we_o=captured we, and mem_addr_o/mem_wdata_o from the capture.
//    - Pulse the owner's gnt. Update last_owner. Return to IDLE.
//  - Read latency:
//    - Cycle 0: req sampled in IDLE. Cycle 1: gnt + mem_en_o. Cycle 2: owner's rvalid pulses.
//    - rdata is loaded from mem_rdata_i in cycle 2 and held until the owner's next read.
//  - Writes produce no rvalid. Throughput is 1 access per 2 clocks, back-to-back allowed.
//  - The requester must hold req/we/addr/wdata stable until gnt. It deasserts req in the cycle after gnt.
//  - A req still high in the IDLE that follows gnt is treated as a new request.
//  - Once captured, an access completes even if req drops or program_mode_i changes. The mode is
//    re-evaluated only in IDLE.
//  - An rvalid in cycle 2 may coincide with a new capture in IDLE. This is independent; the
//    rvalid is routed by a registered owner flag.
//  - Reset asserted mid-access aborts it: no gnt, rvalid or memory enable after reset. last_owner
//    returns to CPU, so the programmer wins the first tie after reset.
//  - Address wraps naturally at AW bits. There is no range check except write protect.
// CONFIGURATION
//  MEM_ARB_WRITE_PROTECT_EN
//   - Defined, with program_mode_i=0: a CPU write with addr < WP_LIMIT is granted normally
//     (c_gnt_o pulses), but mem_en_o=0 and mem_we_o=0 in that cycle. wp_err_o pulses with
//     c_gnt_o and memory is unchanged.
//   - Defined: programmer writes are never blocked.
//   - Not defined: all writes pass through and wp_err_o is tied to 0.
// TESTING
//  - Reset: reset_ni=0 -> all outputs 0.
//  - Reset: release reset with no req -> stays IDLE, mem_en_o=0 forever.
//  - CPU read: c_req addr=4'h3, mem[3]=8'hA5 -> c_gnt_o @+1 with mem_addr_o=3,
//    c_rvalid_o @+2 with c_rdata_o=8'hA5.
//  - Round-robin: program_mode_i=0, p_req and c_req held high for 8 cycles -> grants are
//    P,C,P,C (programmer first after reset), one every 2 clocks.
//  - Program lock: program_mode_i=1, c_req held, p writes 8'h11..8'h44 to addr 0..3 ->
//    4 p_gnt_o, 0 c_gnt_o. Drop program_mode_i -> c_gnt_o follows within 2 clocks.
//  - Abort: reset_ni=0 in the ACCESS cycle of a programmer read -> no p_rvalid_o,
//    memory unchanged.
//  - Write protect, macro defined: CPU writes 8'hFF to addr 2 -> c_gnt_o=1, wp_err_o=1,
//    mem_we_o=0, mem[2] unchanged. Same write to addr 9 -> mem[9]=8'hFF, wp_err_o=0.
//  - Write protect, macro undefined: same write to addr 2 -> mem[2]=8'hFF, wp_err_o=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (programmer / CPU) for a single-port synchronous memory.
// Optional CPU write protection below WP_LIMIT is enabled by defining MEM_ARB_WRITE_PROTECT_EN.
module mem_port_arbiter #(
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH           = 8,
  parameter int WP_LIMIT             = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            program_mode_i,
  input  logic                            p_req_i,
  input  logic                            p_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] p_addr_i,
  input  logic [DATA_WIDTH-1:0]           p_wdata_i,
  output logic                            p_gnt_o,
  output logic                            p_rvalid_o,
  output logic [DATA_WIDTH-1:0]           p_rdata_o,
  input  logic                            c_req_i,
  input  logic                            c_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] c_addr_i,
  input  logic [DATA_WIDTH-1:0]           c_wdata_i,
  output logic                            c_gnt_o,
  output logic                            c_rvalid_o,
  output logic [DATA_WIDTH-1:0]           c_rdata_o,
  output logic                            mem_en_o,
  output logic                            mem_we_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
  output logic                            busy_o,
  output logic                            wp_err_o
);
  localparam int AW = MEMORY_ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

`ifdef MEM_ARB_WRITE_PROTECT_EN
  localparam bit WpEn = 1'b1;
`else
  localparam bit WpEn = 1'b0;
`endif

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e          state_q, state_d;
  logic            last_cpu_q, last_cpu_d;
  logic            own_cpu_q, own_cpu_d;
  logic            p_gnt_q, p_gnt_d;
  logic            c_gnt_q, c_gnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            wp_err_q, wp_err_d;
  logic            p_rvalid_q, p_rvalid_d;
  logic            c_rvalid_q, c_rvalid_d;
  logic [DW-1:0]   p_rdata_q, p_rdata_d;
  logic [DW-1:0]   c_rdata_q, c_rdata_d;

  logic p_elig, c_elig, pick_cpu, sel_we, wp_block;

  always_comb begin
    state_d     = state_q;
    last_cpu_d  = last_cpu_q;
    own_cpu_d   = own_cpu_q;
    p_gnt_d     = 1'b0;
    c_gnt_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wp_err_d    = 1'b0;
    // own_cpu_q still names the owner of the access issued in the previous cycle
    p_rvalid_d  = mem_en_q & ~mem_we_q & ~own_cpu_q;
    c_rvalid_d  = mem_en_q & ~mem_we_q & own_cpu_q;
    p_rdata_d   = p_rvalid_q ? mem_rdata_i : p_rdata_q;
    c_rdata_d   = c_rvalid_q ? mem_rdata_i : c_rdata_q;

    p_elig   = p_req_i;
    c_elig   = c_req_i & ~program_mode_i;
    pick_cpu = c_elig & (~p_elig | ~last_cpu_q);
    sel_we   = pick_cpu ? c_we_i : p_we_i;
    wp_block = WpEn & pick_cpu & c_we_i & (int'(c_addr_i) < WP_LIMIT);

    unique case (state_q)
      IDLE: begin
        if (p_elig || c_elig) begin
          state_d     = ACCESS;
          own_cpu_d   = pick_cpu;
          last_cpu_d  = pick_cpu;
          p_gnt_d     = ~pick_cpu;
          c_gnt_d     = pick_cpu;
          mem_en_d    = ~wp_block;
          mem_we_d    = sel_we & ~wp_block;
          mem_addr_d  = pick_cpu ? c_addr_i : p_addr_i;
          mem_wdata_d = pick_cpu ? c_wdata_i : p_wdata_i;
          wp_err_d    = wp_block;
        end
      end
      ACCESS: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      last_cpu_q  <= 1'b1;
      own_cpu_q   <= 1'b0;
      p_gnt_q     <= 1'b0;
      c_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wp_err_q    <= 1'b0;
      p_rvalid_q  <= 1'b0;
      c_rvalid_q  <= 1'b0;
      p_rdata_q   <= '0;
      c_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_cpu_q  <= last_cpu_d;
      own_cpu_q   <= own_cpu_d;
      p_gnt_q     <= p_gnt_d;
      c_gnt_q     <= c_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wp_err_q    <= wp_err_d;
      p_rvalid_q  <= p_rvalid_d;
      c_rvalid_q  <= c_rvalid_d;
      p_rdata_q   <= p_rdata_d;
      c_rdata_q   <= c_rdata_d;
    end
  end

  assign p_gnt_o     = p_gnt_q;
  assign c_gnt_o     = c_gnt_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wp_err_o    = wp_err_q;
  assign busy_o      = (state_q == ACCESS);
  assign p_rvalid_o  = p_rvalid_q;
  assign c_rvalid_o  = c_rvalid_q;
  // Memory data only arrives in the rvalid cycle, so it is forwarded then and held afterwards.
  assign p_rdata_o   = p_rvalid_q ? mem_rdata_i : p_rdata_q;
  assign c_rdata_o   = c_rvalid_q ? mem_rdata_i : c_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural synchronous memory.
// Expectations follow MEM_ARB_WRITE_PROTECT_EN when it is defined for the build.
module tb_mem_port_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       program_mode = 1'b0;
  logic       p_req = 1'b0, p_we = 1'b0, c_req = 1'b0, c_we = 1'b0;
  logic [3:0] p_addr = '0, c_addr = '0;
  logic [7:0] p_wdata = '0, c_wdata = '0;
  logic       p_gnt_o, p_rvalid_o, c_gnt_o, c_rvalid_o;
  logic [7:0] p_rdata_o, c_rdata_o;
  logic       mem_en_o, mem_we_o, busy_o, wp_err_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata = '0;

`ifdef MEM_ARB_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic [7:0] mem [16] = '{8'h00, 8'h01, 8'h02, 8'hA5, 8'h04, 8'h55, 8'h66, 8'h5C,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

  int checks = 0;
  int failures = 0;
  int p_gnt_cnt = 0, c_gnt_cnt = 0, p_rv_cnt = 0;

  mem_port_arbiter dut (
    .clk_i(clk), .reset_ni(rst_n), .program_mode_i(program_mode),
    .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_gnt_o(p_gnt_o), .p_rvalid_o(p_rvalid_o), .p_rdata_o(p_rdata_o),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
    .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
    .busy_o(busy_o), .wp_err_o(wp_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata <= mem[mem_addr_o];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic cpu; logic we; logic [3:0] addr; logic [7:0] wdata; logic en; logic wp;
  } gexp_t;
  typedef struct packed {logic cpu; logic [7:0] data;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  bit rd_pend = 0, rd_pend_cpu = 0;

  task automatic push_g(input bit cpu, input bit we, input logic [3:0] a, input logic [7:0] d,
                        input bit en, input bit wp);
    gexp_t g;
    g.cpu = cpu; g.we = we; g.addr = a; g.wdata = d; g.en = en; g.wp = wp;
    gq.push_back(g);
  endtask

  task automatic push_r(input bit cpu, input logic [7:0] d);
    rexp_t r;
    r.cpu = cpu; r.data = d;
    rq.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or read-valid
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (!rst_n) begin
      rd_pend = 0;
    end else begin
      if (rd_pend) chk("rvalid_timing", rd_pend_cpu ? c_rvalid_o : p_rvalid_o, 1);
      rd_pend = 0;
      if (p_rvalid_o) p_rv_cnt++;
      if (p_rvalid_o || c_rvalid_o) begin
        chk("rvalid_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          r = rq.pop_front();
          chk("rvalid_owner", {p_rvalid_o, c_rvalid_o}, {~r.cpu, r.cpu});
          chk("rdata", r.cpu ? c_rdata_o : p_rdata_o, r.data);
        end
      end
      if (p_gnt_o || c_gnt_o) begin
        if (p_gnt_o) p_gnt_cnt++;
        if (c_gnt_o) c_gnt_cnt++;
        chk("gnt_expected", gq.size() != 0, 1);
        if (gq.size() != 0) begin
          g = gq.pop_front();
          chk("gnt_owner", {p_gnt_o, c_gnt_o}, {~g.cpu, g.cpu});
          chk("mem_en", mem_en_o, g.en);
          chk("mem_we", mem_we_o, g.we & g.en);
          chk("mem_addr", mem_addr_o, g.addr);
          if (g.we) chk("mem_wdata", mem_wdata_o, g.wdata);
          chk("wp_err", wp_err_o, g.wp);
          chk("busy_in_access", busy_o, 1);
          if (g.en && !g.we) begin rd_pend = 1; rd_pend_cpu = g.cpu; end
        end
      end else begin
        chk("no_gnt_mem_quiet", {mem_en_o, wp_err_o}, 0);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic access(input bit cpu, input bit we, input logic [3:0] a, input logic [7:0] d,
                        output int lat);
    bit found = 0;
    @(posedge clk); #1;
    if (cpu) begin c_req = 1; c_we = we; c_addr = a; c_wdata = d; end
    else     begin p_req = 1; p_we = we; p_addr = a; p_wdata = d; end
    lat = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (cpu ? c_gnt_o : p_gnt_o) begin found = 1; lat = i; end
    end
    if (!found) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    if (cpu) c_req = 0; else p_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, pc, cc, rv;
    bit found;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {p_gnt_o, p_rvalid_o, p_rdata_o, c_gnt_o, c_rvalid_o, c_rdata_o,
                          mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, wp_err_o}, 0);
    rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", {busy_o, mem_en_o}, 0);
    end

    // CPU read of addr 3: grant one cycle after sampling, rvalid one cycle later
    push_g(1, 0, 4'h3, 8'h00, 1, 0);
    push_r(1, 8'hA5);
    access(1, 0, 4'h3, 8'h00, lat);
    chk("cpu_rd_gnt_latency", lat, 2);
    wait_cycles(2);

    push_g(0, 0, 4'h5, 8'h00, 1, 0);
    push_r(0, 8'h55);
    access(0, 0, 4'h5, 8'h00, lat);
    wait_cycles(2);
    @(negedge clk);
    chk("c_rdata_held", c_rdata_o, 8'hA5);
    chk("p_rdata_held", p_rdata_o, 8'h55);

    // Program lock: CPU waits while the programmer writes addr 0..3
    @(posedge clk); #1;
    program_mode = 1;
    c_req = 1; c_we = 0; c_addr = 4'h1;
    for (int k = 0; k < 4; k++) push_g(0, 1, 4'(k), 8'(8'h11 * (k + 1)), 1, 0);
    push_g(1, 0, 4'h1, 8'h00, 1, 0);
    push_r(1, 8'h22);
    pc = p_gnt_cnt; cc = c_gnt_cnt;
    for (int k = 0; k < 4; k++) access(0, 1, 4'(k), 8'(8'h11 * (k + 1)), lat);
    chk("lock_p_gnts", p_gnt_cnt - pc, 4);
    chk("lock_c_gnts", c_gnt_cnt - cc, 0);
    @(posedge clk); #1;
    program_mode = 0;
    found = 0;
    for (int i = 1; i <= 2 && !found; i++) begin
      @(negedge clk);
      if (c_gnt_o) found = 1;
    end
    chk("unlock_c_gnt_within_2", found, 1);
    @(posedge clk); #1;
    c_req = 0;
    wait_cycles(3);
    chk("mem0_written", mem[0], 8'h11);
    chk("mem3_written", mem[3], 8'h44);

    // Abort: reset asserted during the ACCESS cycle of a programmer read
    rv = p_rv_cnt;
    @(posedge clk); #1;
    p_req = 1; p_we = 0; p_addr = 4'h7;
    @(posedge clk); #1;
    rst_n = 0;
    p_req = 0;
    wait_cycles(2);
    @(negedge clk);
    chk("abort_outputs_zero", {p_gnt_o, p_rvalid_o, mem_en_o, busy_o}, 0);
    rst_n = 1;
    wait_cycles(4);
    chk("abort_no_rvalid", p_rv_cnt - rv, 0);
    chk("abort_mem7", mem[7], 8'h5C);

    // Round-robin after reset: programmer first, then alternating
    pc = p_gnt_cnt; cc = c_gnt_cnt;
    for (int k = 0; k < 2; k++) begin
      push_g(0, 0, 4'h5, 8'h00, 1, 0); push_r(0, 8'h55);
      push_g(1, 0, 4'h6, 8'h00, 1, 0); push_r(1, 8'h66);
    end
    @(posedge clk); #1;
    p_req = 1; p_we = 0; p_addr = 4'h5;
    c_req = 1; c_we = 0; c_addr = 4'h6;
    repeat (8) @(posedge clk);
    #1;
    p_req = 0; c_req = 0;
    wait_cycles(3);
    chk("rr_p_gnts", p_gnt_cnt - pc, 2);
    chk("rr_c_gnts", c_gnt_cnt - cc, 2);

    // Write protect boundary: addr 2 (protected when enabled) and addr 9
    push_g(1, 1, 4'h2, 8'hFF, !WP, WP);
    access(1, 1, 4'h2, 8'hFF, lat);
    wait_cycles(2);
    chk("wp_mem2", mem[2], WP ? 8'h33 : 8'hFF);
    push_g(1, 1, 4'h9, 8'hFF, 1, 0);
    access(1, 1, 4'h9, 8'hFF, lat);
    wait_cycles(2);
    chk("wp_mem9", mem[9], 8'hFF);

    wait_cycles(2);
    chk("gnt_queue_drained", gq.size(), 0);
    chk("rd_queue_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
